// File: rtl/mem_access_bridge_pkg.sv
// Shared types and widths for the core-to-bus memory access bridge.
package HighLevelControl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_W = 4;
    localparam int unsigned OFF_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } memBridgeState;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_TIMEOUT    = 2'b10,
        CAUSE_BUS_ERROR  = 2'b11
    } memFaultCause;

    // Lane-aligned request payload held stable while the bus owns it.
    typedef struct packed {
        logic              write;
        logic [LANE_W-1:0] byte_en;
        logic [DATA_W-1:0] wdata;
    } bus_payload_t;

endpackage

// File: rtl/mem_access_bridge_byte_lane_aligner.sv
// Combinational lane shifter: moves core byte lanes onto the bus word and
// bus read data back to a right-justified core value; flags misalignment.
module byte_lane_aligner
    import HighLevelControl::*;
(
    input  logic [OFF_W-1:0]  off,
    input  logic [LANE_W-1:0] byte_en,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [LANE_W-1:0] lane_en,
    output logic [DATA_W-1:0] lane_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              misaligned
);

    logic [2*LANE_W-1:0] lane_wide;
    logic [4:0]          bit_shift;

    always_comb begin
        lane_wide  = {LANE_W'(0), byte_en} << off;
        bit_shift  = {off, 3'b000};
        lane_en    = lane_wide[LANE_W-1:0];
        // Any lane pushed past byte 3, or no lanes at all, cannot be issued.
        misaligned = (lane_wide[2*LANE_W-1:LANE_W] != '0) || (byte_en == '0);
        lane_wdata = core_wdata << bit_shift;
        core_rdata = bus_rdata >> bit_shift;
    end

endmodule

// File: rtl/mem_access_bridge.sv
// Bridge between the core memory port and the data bus: one access at a time,
// with lane alignment, misalignment/timeout/bus-error faults and core stall.
module mem_access_bridge
    import HighLevelControl::*;
#(
    parameter int unsigned BIT_COUNT      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemEn,
    input  logic                 MemWrite,
    input  logic [3:0]           ByteEn,
    input  logic [BIT_COUNT-1:0] MemAdr,
    input  logic [31:0]          MemWriteData,
    output logic [31:0]          MemReadData,
    output logic                 Stall,
    output logic                 Fault,
    output logic [1:0]           FaultCause,
    output logic                 BusValid,
    input  logic                 BusReady,
    output logic                 BusWrite,
    output logic [3:0]           BusByteEn,
    output logic [BIT_COUNT-1:0] BusAdr,
    output logic [31:0]          BusWriteData,
    input  logic                 BusRspValid,
    input  logic [31:0]          BusRspData,
    input  logic                 BusRspError
);

    if (BIT_COUNT != 32 && BIT_COUNT != 64) begin : g_bad_width
        $error("mem_access_bridge: BIT_COUNT must be 32 or 64");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("mem_access_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_REQ  = 2'(REQ);
    localparam logic [1:0] S_RSP  = 2'(RSP);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [OFF_W-1:0]  off_q, off_sel;
    logic [1:0]        cause_n;
    logic              latch_req;
    logic              capture_en;
    logic [DATA_W-1:0] capture_data;
    bus_payload_t      req_q;

    logic [LANE_W-1:0] lane_en;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              misaligned;

    // Live offset while accepting a request, latched offset while reading back.
    assign off_sel = (state_q == S_IDLE) ? MemAdr[1:0] : off_q;

    byte_lane_aligner u_aligner (
        .off        (off_sel),
        .byte_en    (ByteEn),
        .core_wdata (MemWriteData),
        .bus_rdata  (BusRspData),
        .lane_en    (lane_en),
        .lane_wdata (lane_wdata),
        .core_rdata (core_rdata),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next state, fault cause, capture control and core stall.
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        cause_n      = CAUSE_NONE;
        latch_req    = 1'b0;
        capture_en   = 1'b0;
        capture_data = '0;
        Stall        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MemEn) begin
                    Stall = 1'b1;
                    if (misaligned) begin
                        state_n = S_DONE;
                        cause_n = CAUSE_MISALIGNED;
                    end else begin
                        state_n   = S_REQ;
                        latch_req = 1'b1;
                        cnt_n     = '0;
                    end
                end
            end
            S_REQ: begin
                Stall = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_n    = S_DONE;
                    cause_n    = CAUSE_TIMEOUT;
                    capture_en = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                    if (BusReady) begin
                        state_n = S_RSP;
                    end
                end
            end
            S_RSP: begin
                Stall = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_n    = S_DONE;
                    cause_n    = CAUSE_TIMEOUT;
                    capture_en = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                    if (BusRspValid) begin
                        state_n      = S_DONE;
                        capture_en   = 1'b1;
                        capture_data = req_q.write ? '0 : core_rdata;
                        cause_n      = BusRspError ? CAUSE_BUS_ERROR : CAUSE_NONE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (!reset) begin
            Stall = 1'b0;
        end
    end

    // Registered bus request, read data and fault reporting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q       <= '0;
            off_q       <= '0;
            BusAdr      <= '0;
            BusValid    <= 1'b0;
            MemReadData <= '0;
            Fault       <= 1'b0;
            FaultCause  <= 2'b00;
        end else begin
            BusValid   <= (state_n == S_REQ);
            Fault      <= (state_n == S_DONE) && (cause_n != CAUSE_NONE);
            FaultCause <= (state_n == S_DONE) ? cause_n : 2'b00;
            if (latch_req) begin
                req_q.write   <= MemWrite;
                req_q.byte_en <= lane_en;
                req_q.wdata   <= lane_wdata;
                off_q         <= MemAdr[1:0];
                BusAdr        <= {MemAdr[BIT_COUNT-1:2], 2'b00};
            end
            if (capture_en) begin
                MemReadData <= capture_data;
            end
        end
    end

    assign BusWrite     = req_q.write;
    assign BusByteEn    = req_q.byte_en;
    assign BusWriteData = req_q.wdata;

endmodule

// File: tb/tb_mem_access_bridge.sv
// Directed self-checking bench for mem_access_bridge (32-bit address, 8-cycle timeout).
module tb_mem_access_bridge;

    logic        clk;
    logic        reset;
    logic        MemEn;
    logic        MemWrite;
    logic [3:0]  ByteEn;
    logic [31:0] MemAdr;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;
    logic        Stall;
    logic        Fault;
    logic [1:0]  FaultCause;
    logic        BusValid;
    logic        BusReady;
    logic        BusWrite;
    logic [3:0]  BusByteEn;
    logic [31:0] BusAdr;
    logic [31:0] BusWriteData;
    logic        BusRspValid;
    logic [31:0] BusRspData;
    logic        BusRspError;

    int errors = 0;
    int checks = 0;

    mem_access_bridge #(
        .BIT_COUNT      (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemEn        (MemEn),
        .MemWrite     (MemWrite),
        .ByteEn       (ByteEn),
        .MemAdr       (MemAdr),
        .MemWriteData (MemWriteData),
        .MemReadData  (MemReadData),
        .Stall        (Stall),
        .Fault        (Fault),
        .FaultCause   (FaultCause),
        .BusValid     (BusValid),
        .BusReady     (BusReady),
        .BusWrite     (BusWrite),
        .BusByteEn    (BusByteEn),
        .BusAdr       (BusAdr),
        .BusWriteData (BusWriteData),
        .BusRspValid  (BusRspValid),
        .BusRspData   (BusRspData),
        .BusRspError  (BusRspError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; MemEn = 1'b0; MemWrite = 1'b0; ByteEn = 4'b0000;
        MemAdr = 32'h0; MemWriteData = 32'h0; BusReady = 1'b0;
        BusRspValid = 1'b0; BusRspData = 32'h0; BusRspError = 1'b0;

        // Reset values, with a request pending to show Stall is held low.
        tick(); tick();
        MemEn = 1'b1; #1;
        chk("rst_busvalid", 64'(BusValid), 64'd0);
        chk("rst_buswrite", 64'(BusWrite), 64'd0);
        chk("rst_busbyteen", 64'(BusByteEn), 64'd0);
        chk("rst_busadr", 64'(BusAdr), 64'd0);
        chk("rst_buswdata", 64'(BusWriteData), 64'd0);
        chk("rst_memrdata", 64'(MemReadData), 64'd0);
        chk("rst_fault", 64'(Fault), 64'd0);
        chk("rst_cause", 64'(FaultCause), 64'd0);
        chk("rst_stall", 64'(Stall), 64'd0);

        // Load 0x1002 / 0011, request presented as reset releases.
        reset = 1'b1; MemWrite = 1'b0; ByteEn = 4'b0011; MemAdr = 32'h1002; BusReady = 1'b1;
        #1; chk("ld_stall_c0", 64'(Stall), 64'd1);
        tick();
        chk("ld_busvalid", 64'(BusValid), 64'd1);
        chk("ld_busadr", 64'(BusAdr), 64'h1000);
        chk("ld_busbyteen", 64'(BusByteEn), 64'b1100);
        chk("ld_buswrite", 64'(BusWrite), 64'd0);
        chk("ld_stall_c1", 64'(Stall), 64'd1);
        tick();
        BusReady = 1'b0; BusRspValid = 1'b1; BusRspData = 32'hAABBCCDD; #1;
        chk("ld_rsp_busvalid", 64'(BusValid), 64'd0);
        chk("ld_stall_c2", 64'(Stall), 64'd1);
        tick();
        BusRspValid = 1'b0;
        chk("ld_done_stall", 64'(Stall), 64'd0);
        chk("ld_done_fault", 64'(Fault), 64'd0);
        chk("ld_done_cause", 64'(FaultCause), 64'd0);
        chk("ld_done_data", 64'(MemReadData), 64'h0000AABB);
        MemEn = 1'b0;
        tick();
        // Stray response in IDLE must not disturb the held read data.
        BusRspValid = 1'b1; BusRspData = 32'h55555555; #1;
        chk("idle_stall", 64'(Stall), 64'd0);
        tick();
        BusRspValid = 1'b0;
        chk("idle_ignore_rsp", 64'(MemReadData), 64'h0000AABB);
        chk("idle_no_valid", 64'(BusValid), 64'd0);

        // Store 0x2001 / 0001 / 0x5A, one response wait.
        MemEn = 1'b1; MemWrite = 1'b1; ByteEn = 4'b0001; MemAdr = 32'h2001;
        MemWriteData = 32'h5A; BusReady = 1'b1;
        tick();
        chk("st_busbyteen", 64'(BusByteEn), 64'b0010);
        chk("st_buswdata", 64'(BusWriteData), 64'h00005A00);
        chk("st_buswrite", 64'(BusWrite), 64'd1);
        chk("st_busadr", 64'(BusAdr), 64'h2000);
        tick();
        BusReady = 1'b0;
        tick();
        chk("st_wait_stall", 64'(Stall), 64'd1);
        BusRspValid = 1'b1;
        tick();
        BusRspValid = 1'b0;
        chk("st_done_stall", 64'(Stall), 64'd0);
        chk("st_done_fault", 64'(Fault), 64'd0);
        chk("st_done_data", 64'(MemReadData), 64'd0);
        MemEn = 1'b0; MemWrite = 1'b0;
        tick();

        // Back-to-back loads, two ready waits each; second gets a bus error.
        MemEn = 1'b1; ByteEn = 4'b0001; MemAdr = 32'h5001; BusReady = 1'b0;
        tick(); tick();
        chk("b2b_wait_valid", 64'(BusValid), 64'd1);
        BusReady = 1'b1;
        tick();
        BusReady = 1'b0; BusRspValid = 1'b1; BusRspData = 32'h11223344;
        tick();
        BusRspValid = 1'b0;
        chk("b2b1_data", 64'(MemReadData), 64'h00112233);
        chk("b2b1_fault", 64'(Fault), 64'd0);
        MemAdr = 32'h6000; ByteEn = 4'b1111;
        tick();
        chk("b2b2_stall_c0", 64'(Stall), 64'd1);
        tick();
        chk("b2b2_busadr", 64'(BusAdr), 64'h6000);
        chk("b2b2_busbyteen", 64'(BusByteEn), 64'b1111);
        tick();
        BusReady = 1'b1;
        tick();
        BusReady = 1'b0; BusRspValid = 1'b1; BusRspError = 1'b1; BusRspData = 32'hDEADBEEF;
        tick();
        BusRspValid = 1'b0; BusRspError = 1'b0;
        chk("b2b2_fault", 64'(Fault), 64'd1);
        chk("b2b2_cause", 64'(FaultCause), 64'b11);
        MemEn = 1'b0;
        tick();
        chk("b2b_idle_fault", 64'(Fault), 64'd0);

        // Timeout: ready withheld until the last counted cycle, where it must lose.
        MemEn = 1'b1; ByteEn = 4'b1111; MemAdr = 32'h4000; BusReady = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) BusReady = 1'b1;
            #1;
            chk("to_valid", 64'(BusValid), 64'd1);
            chk("to_stall", 64'(Stall), 64'd1);
        end
        tick();
        BusReady = 1'b0;
        chk("to_fault", 64'(Fault), 64'd1);
        chk("to_cause", 64'(FaultCause), 64'b10);
        chk("to_data", 64'(MemReadData), 64'd0);
        chk("to_valid_done", 64'(BusValid), 64'd0);
        MemEn = 1'b0;
        tick();
        chk("to_idle_stall", 64'(Stall), 64'd0);
        chk("to_idle_cause", 64'(FaultCause), 64'd0);

        // Misaligned 0x3003 / 1111: fault in the second cycle, no bus activity.
        MemEn = 1'b1; ByteEn = 4'b1111; MemAdr = 32'h3003; BusReady = 1'b1;
        #1; chk("mis_stall_c0", 64'(Stall), 64'd1);
        tick();
        chk("mis_fault", 64'(Fault), 64'd1);
        chk("mis_cause", 64'(FaultCause), 64'b01);
        chk("mis_no_valid", 64'(BusValid), 64'd0);
        chk("mis_stall_done", 64'(Stall), 64'd0);
        MemEn = 1'b0;
        tick();
        chk("mis_idle_fault", 64'(Fault), 64'd0);
        chk("mis_idle_valid", 64'(BusValid), 64'd0);

        // Empty byte enable counts as misaligned.
        MemEn = 1'b1; ByteEn = 4'b0000; MemAdr = 32'h0010;
        tick();
        chk("zero_be_cause", 64'(FaultCause), 64'b01);
        chk("zero_be_valid", 64'(BusValid), 64'd0);
        MemEn = 1'b0; BusReady = 1'b0;
        tick();

        // Reset in RSP, then a late response after release.
        MemEn = 1'b1; ByteEn = 4'b1111; MemAdr = 32'h7000; BusReady = 1'b1;
        tick();
        tick();
        BusReady = 1'b0; #1;
        chk("rr_in_rsp_stall", 64'(Stall), 64'd1);
        reset = 1'b0; #1;
        chk("rr_valid", 64'(BusValid), 64'd0);
        chk("rr_stall", 64'(Stall), 64'd0);
        tick();
        reset = 1'b1; MemEn = 1'b0; BusRspValid = 1'b1; BusRspData = 32'h99999999;
        tick();
        BusRspValid = 1'b0;
        chk("rr_no_capture", 64'(MemReadData), 64'd0);
        chk("rr_no_fault", 64'(Fault), 64'd0);
        chk("rr_idle_stall", 64'(Stall), 64'd0);
        chk("rr_idle_valid", 64'(BusValid), 64'd0);

        // Recovery: zero-wait load at offset 3.
        MemEn = 1'b1; ByteEn = 4'b0001; MemAdr = 32'h8003; BusReady = 1'b1;
        tick();
        chk("rec_busbyteen", 64'(BusByteEn), 64'b1000);
        tick();
        BusReady = 1'b0; BusRspValid = 1'b1; BusRspData = 32'h12345678;
        tick();
        BusRspValid = 1'b0; MemEn = 1'b0;
        chk("rec_data", 64'(MemReadData), 64'h00000012);
        chk("rec_stall", 64'(Stall), 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_bridge.md
MEM_ACCESS_BRIDGE -- requirements
Module: mem_access_bridge

Interface
REQ-001 Parameter BIT_COUNT, default 32: core address width; only 32 and 64 are legal, and any other value is an elaboration error.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles spent in REQ plus RSP before the bridge aborts.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 MemEn  in  1  core requests a data access.
REQ-006 MemWrite  in  1  1 = store, 0 = load.
REQ-007 ByteEn  in  4  core byte lanes, relative to offset 0.
REQ-008 MemAdr  in  BIT_COUNT  core byte address.
REQ-009 MemWriteData  in  32  store data, right-justified.
REQ-010 MemReadData  out  32  load data, right-justified.
REQ-011 Stall  out  1  core holds its PC and request while this is 1.
REQ-012 Fault  out  1  one-cycle pulse, asserted in DONE when the access failed.
REQ-013 FaultCause  out  2  failure reason: 00 none, 01 misaligned, 10 timeout, 11 bus error.
REQ-014 BusValid  out  1  bus request valid.
REQ-015 BusReady  in  1  bus accepts the request.
REQ-016 BusWrite  out  1  bus store flag.
REQ-017 BusByteEn  out  4  byte lanes, aligned to the bus word.
REQ-018 BusAdr  out  BIT_COUNT  word-aligned bus address.
REQ-019 BusWriteData  out  32  store data, lane-aligned.
REQ-020 BusRspValid  in  1  bus response or store acknowledge.
REQ-021 BusRspData  in  32  load response data.
REQ-022 BusRspError  in  1  bus error, qualified by BusRspValid.

Function
REQ-023 The FSM states SHALL be IDLE, REQ, RSP and DONE.
REQ-024 IDLE with MemEn=0: remain in IDLE; Stall=0.
REQ-025 IDLE with MemEn=1: Stall=1 combinationally in that same cycle; latch the request; go to REQ, or go to DONE with cause 01 if misaligned.
REQ-026 Offset off = MemAdr[1:0]; BusAdr = MemAdr with bits [1:0] cleared.
REQ-027 BusByteEn = ByteEn << off, truncated to 4 bits; the access is misaligned if any set bit shifts out, or if ByteEn = 0000.
REQ-028 BusWriteData = MemWriteData << (8*off), truncated to 32 bits.
REQ-029 A misaligned access SHALL issue no bus transaction.
REQ-030 REQ: BusValid=1, with all Bus* outputs stable; a transfer occurs on an edge with BusValid and BusReady both 1, and the FSM then goes to RSP.
REQ-031 RSP: BusValid=0.
  - On BusRspValid=1, capture (BusRspData >> 8*off) for loads, or 0 for stores.
  - Go to DONE with cause 11 if BusRspError=1, else cause 00.
REQ-032 BusRspValid SHALL be ignored in every state other than RSP.
REQ-033 A cycle counter clears on entry to REQ and increments each cycle in REQ or RSP.
  - Reaching TIMEOUT_CYCLES forces DONE with cause 10 and MemReadData=0.
  - A timeout takes priority over a same-cycle BusReady or BusRspValid.
REQ-034 DONE: Stall=0; MemReadData holds the captured value; Fault=1 iff cause≠00; FaultCause is driven.
  - The next state is always IDLE, even though MemEn is still 1 in this cycle, so no duplicate access occurs.
REQ-035 MemReadData SHALL hold its last captured value until the next capture.
REQ-036 Fault and FaultCause SHALL be 0 outside DONE.
REQ-037 Latency: a load with zero bus wait states returns in DONE 3 cycles after the request cycle, so Stall is high for 3 cycles.

Reset
REQ-038 While reset=0, asynchronously:
  - state=IDLE, counter=0;
  - BusValid=0, BusWrite=0, BusByteEn=0, BusAdr=0, BusWriteData=0;
  - MemReadData=0, Fault=0, FaultCause=00, Stall=0.
REQ-039 Reset asserted mid-transaction SHALL drop BusValid immediately; a late BusRspValid arriving afterwards SHALL be ignored.
REQ-040 The first request can be accepted on the first rising edge after reset deasserts.

Structure
REQ-041 Enums memBridgeState (IDLE/REQ/RSP/DONE) and memFaultCause SHALL be added to package HighLevelControl.
REQ-042 The lane shifting and the misalignment check SHALL be placed in one combinational sub-module, byte_lane_aligner, shared by the write and read paths.
REQ-043 The bridge SHALL sit between computeCore's memory port and the data bus, with Stall gating the core's PC register enable.

Verification
REQ-044 Load: MemAdr=0x1002, ByteEn=0011, bus responds 0xAABBCCDD with zero waits -> BusAdr=0x1000, BusByteEn=1100, MemReadData=0x0000AABB, Stall high 3 cycles.
REQ-045 Store: MemAdr=0x2001, ByteEn=0001, MemWriteData=0x5A -> BusByteEn=0010, BusWriteData=0x00005A00, BusWrite=1; DONE after ack.
REQ-046 Misaligned: MemAdr=0x3003, ByteEn=1111 -> BusValid never asserts; Fault pulses with FaultCause=01 in the 2nd cycle.
REQ-047 Timeout: TIMEOUT_CYCLES=8, BusReady held 0 -> Fault with cause 10 after 8 cycles; MemReadData=0; back to IDLE.
REQ-048 Reset mid-RSP, followed by BusRspValid=1 -> no capture; Stall=0; BusValid=0; state IDLE.
REQ-049 Back-to-back loads with BusReady waits of 2 cycles and BusRspError=1 on the second load -> the first load returns its data, and the second reports cause 11.
